// File: rtl/simple_bus_rr_mux.sv
// simple_bus_rr_mux
//   N-channel merge stage. Every input channel writes into its own FIFO
//   (DEPTH entries). An arbiter drains the FIFOs into a single registered
//   output. PRIO_MODE=0 selects round-robin and PRIO_MODE=1 selects fixed
//   priority, where the lowest index wins. Each output beat carries
//   out_id = ID_BASE + source channel index.
//
// Handshake: a beat moves across an interface on a rising clk edge where
//   valid && ready. Inputs use in_valid[i]/in_ready[i]. The output uses
//   out_valid/out_ready. in_ready[i] depends only on FIFO i state. Once the
//   output holds a beat that is not accepted, out_valid/out_data/out_id stay
//   stable until out_ready is seen.
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   in_valid/ready  per-channel handshake; bit i belongs to channel i
//   in_data         channel i occupies [i*DATA_W +: DATA_W]
//   out_valid/ready output handshake (registered output)
//   out_data/out_id payload and source tag of the held beat
//   fifo_level      per-channel occupancy 0..DEPTH, ($clog2(DEPTH)+1) bits each
module simple_bus_rr_mux #(
  parameter int NUM_CH    = 10,
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 4,
  parameter int ID_BASE   = 100,
  parameter int ID_W      = 8,
  parameter int PRIO_MODE = 0
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_CH-1:0]                     in_valid,
  output logic [NUM_CH-1:0]                     in_ready,
  input  logic [NUM_CH*DATA_W-1:0]              in_data,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [DATA_W-1:0]                     out_data,
  output logic [ID_W-1:0]                       out_id,
  output logic [NUM_CH*($clog2(DEPTH)+1)-1:0]   fifo_level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0] nonempty;
  logic [NUM_CH-1:0] pop;
  logic [DATA_W-1:0] head_data [NUM_CH];

  logic              load;
  logic              grant_found;
  logic [IDX_W-1:0]  grant_idx;

  logic [IDX_W-1:0]  rr_ptr_q,    rr_ptr_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q,  out_data_d;
  logic [ID_W-1:0]   out_id_q,    out_id_d;

  // The output register may take a new beat when it is empty or being drained.
  assign load = !out_valid_q || out_ready;

  // ---------------------------------------------------------------------------
  // Per-channel FIFOs
  // ---------------------------------------------------------------------------
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q,  level_d;
    logic              full;
    logic              push;

    // Ready depends only on occupancy. A full FIFO refuses a write even when
    // it is being popped in the same cycle.
    assign full                        = (level_q == LVL_W'(DEPTH));
    assign in_ready[i]                 = !full;
    assign push                        = in_valid[i] && !full;
    assign nonempty[i]                 = (level_q != '0);
    assign pop[i]                      = load && grant_found && (grant_idx == IDX_W'(i));
    assign head_data[i]                = mem_q[rd_ptr_q];
    assign fifo_level[i*LVL_W +: LVL_W] = level_q;

    always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      // DEPTH is a power of two, so the pointers wrap naturally.
      if (push)   wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop[i]) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop[i]})
        2'b10:   level_d = level_q + LVL_W'(1);
        2'b01:   level_d = level_q - LVL_W'(1);
        default: level_d = level_q;
      endcase
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        level_q  <= '0;
      end else begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        level_q  <= level_d;
      end
    end

    // Storage is not reset. The pointers and level define what is valid.
    always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= in_data[i*DATA_W +: DATA_W];
    end
  end

  // ---------------------------------------------------------------------------
  // Arbiter
  // ---------------------------------------------------------------------------
  // Round-robin scan: first search the channels above the pointer, then wrap
  // to the channels at or below it. This is the same order as pointer+1 upward
  // modulo NUM_CH.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    if (PRIO_MODE == 0) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (!grant_found && nonempty[c] && (IDX_W'(c) > rr_ptr_q)) begin
          grant_found = 1'b1;
          grant_idx   = IDX_W'(c);
        end
      end
      for (int c = 0; c < NUM_CH; c++) begin
        if (!grant_found && nonempty[c] && (IDX_W'(c) <= rr_ptr_q)) begin
          grant_found = 1'b1;
          grant_idx   = IDX_W'(c);
        end
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (!grant_found && nonempty[c]) begin
          grant_found = 1'b1;
          grant_idx   = IDX_W'(c);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output register and round-robin pointer
  // ---------------------------------------------------------------------------
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_id_d    = out_id_q;
    rr_ptr_d    = rr_ptr_q;
    if (load) begin
      if (grant_found) begin
        out_valid_d = 1'b1;
        out_data_d  = head_data[grant_idx];
        out_id_d    = ID_W'(ID_BASE + int'(grant_idx));
        rr_ptr_d    = grant_idx;
      end else begin
        // Nothing to send. Payload and tag keep their last values.
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
      rr_ptr_q    <= IDX_W'(NUM_CH - 1);
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_id    = out_id_q;

endmodule

// File: tb/tb_simple_bus_rr_mux.sv
module tb_simple_bus_rr_mux;
  localparam int NUM_CH  = 10;
  localparam int DATA_W  = 8;
  localparam int DEPTH   = 4;
  localparam int ID_BASE = 100;
  localparam int ID_W    = 8;
  localparam int LVL_W   = $clog2(DEPTH) + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NUM_CH-1:0]        in_valid = '0;
  logic [NUM_CH*DATA_W-1:0] in_data  = '0;
  logic                     out_ready = 1'b0;

  // index 0: round-robin instance, index 1: fixed-priority instance
  logic [NUM_CH-1:0]        in_ready_rr,   in_ready_fp;
  logic                     out_valid_rr,  out_valid_fp;
  logic [DATA_W-1:0]        out_data_rr,   out_data_fp;
  logic [ID_W-1:0]          out_id_rr,     out_id_fp;
  logic [NUM_CH*LVL_W-1:0]  fifo_level_rr, fifo_level_fp;

  simple_bus_rr_mux #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEPTH(DEPTH),
    .ID_BASE(ID_BASE), .ID_W(ID_W), .PRIO_MODE(0)) dut_rr (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_rr),
    .in_data(in_data), .out_valid(out_valid_rr), .out_ready(out_ready),
    .out_data(out_data_rr), .out_id(out_id_rr), .fifo_level(fifo_level_rr));

  simple_bus_rr_mux #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEPTH(DEPTH),
    .ID_BASE(ID_BASE), .ID_W(ID_W), .PRIO_MODE(1)) dut_fp (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_fp),
    .in_data(in_data), .out_valid(out_valid_fp), .out_ready(out_ready),
    .out_data(out_data_fp), .out_id(out_id_fp), .fifo_level(fifo_level_fp));

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- reference model ----------------
  // Each channel is an ordered list: index 0 is the oldest entry.
  logic [DATA_W-1:0] m_fifo [2][NUM_CH][DEPTH];
  int                m_cnt  [2][NUM_CH];
  logic              m_ov   [2];
  logic [DATA_W-1:0] m_od   [2];
  logic [ID_W-1:0]   m_oid  [2];
  int                m_ptr  [2];

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      for (int c = 0; c < NUM_CH; c++) m_cnt[m][c] = 0;
      m_ov[m] = 1'b0; m_od[m] = '0; m_oid[m] = '0; m_ptr[m] = NUM_CH - 1;
    end
  endtask

  // One clock edge of mode m, computed from the current inputs.
  task automatic model_step(input int m);
    int start_cnt [NUM_CH];
    int g;
    int c;
    for (int k = 0; k < NUM_CH; k++) start_cnt[k] = m_cnt[m][k];
    if (!m_ov[m] || out_ready) begin
      g = -1;
      for (int k = 1; k <= NUM_CH; k++) begin
        c = (m == 0) ? (m_ptr[m] + k) % NUM_CH : k - 1;
        if (g < 0 && start_cnt[c] > 0) g = c;
      end
      if (g >= 0) begin
        m_od[m] = m_fifo[m][g][0];
        for (int k = 0; k < DEPTH - 1; k++) m_fifo[m][g][k] = m_fifo[m][g][k+1];
        m_cnt[m][g]--;
        m_oid[m] = ID_W'(ID_BASE + g);
        m_ov[m]  = 1'b1;
        m_ptr[m] = g;
      end else begin
        m_ov[m] = 1'b0;
      end
    end
    for (int k = 0; k < NUM_CH; k++) begin
      if (in_valid[k] && start_cnt[k] < DEPTH) begin
        m_fifo[m][k][m_cnt[m][k]] = in_data[k*DATA_W +: DATA_W];
        m_cnt[m][k]++;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change at the falling edge. Outputs are sampled at the falling edge.
  task automatic tick();
    @(posedge clk);
    if (!rst) begin model_step(0); model_step(1); end
    @(negedge clk);
  endtask

  task automatic do_reset();
    in_valid = '0; in_data = '0; out_ready = 1'b0; rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    model_reset();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    n_tests++; if (out_valid_rr !== 1'b0 || out_valid_fp !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b/%b exp 0", out_valid_rr, out_valid_fp); end
    n_tests++; if (out_id_rr !== 8'd0 || out_data_rr !== 8'd0) begin n_fail++; $display("FAIL reset_id_data got %0d/%0d exp 0/0", out_id_rr, out_data_rr); end
    n_tests++; if (in_ready_rr !== '1 || in_ready_fp !== '1) begin n_fail++; $display("FAIL reset_ready got %h/%h exp 3ff", in_ready_rr, in_ready_fp); end
    // queue data on every channel, then reset in the middle of a cycle
    in_valid = '1;
    for (int c = 0; c < NUM_CH; c++) in_data[c*DATA_W +: DATA_W] = 8'($urandom);
    tick(); tick(); tick();
    in_valid = '0;
    #2 rst = 1'b1;
    #1;
    n_tests++; if (out_valid_rr !== 1'b0 || out_valid_fp !== 1'b0) begin n_fail++; $display("FAIL async_rst_valid got %b/%b exp 0", out_valid_rr, out_valid_fp); end
    n_tests++; if (out_id_rr !== 8'd0 || out_id_fp !== 8'd0 || out_data_rr !== 8'd0) begin n_fail++; $display("FAIL async_rst_id got %0d/%0d exp 0", out_id_rr, out_id_fp); end
    n_tests++; if (in_ready_rr !== '1 || in_ready_fp !== '1) begin n_fail++; $display("FAIL async_rst_ready got %h/%h exp 3ff", in_ready_rr, in_ready_fp); end
    n_tests++; if (fifo_level_rr !== '0 || fifo_level_fp !== '0) begin n_fail++; $display("FAIL async_rst_level got %h/%h exp 0", fifo_level_rr, fifo_level_fp); end
    tick();
    rst = 1'b0; model_reset();
    out_ready = 1'b1;
    tick(); tick();
    n_tests++; if (out_valid_rr !== 1'b0) begin n_fail++; $display("FAIL rst_discard got %b exp 0", out_valid_rr); end
  endtask

  task automatic test_single_beat();
    do_reset();
    out_ready = 1'b1;
    in_valid[3] = 1'b1; in_data[3*DATA_W +: DATA_W] = 8'hA5;
    tick();
    in_valid = '0;
    n_tests++; if (out_valid_rr !== 1'b0) begin n_fail++; $display("FAIL single_no_bypass got %b exp 0", out_valid_rr); end
    tick();
    n_tests++; if (out_valid_rr !== 1'b1 || out_data_rr !== 8'hA5 || out_id_rr !== 8'd103) begin n_fail++; $display("FAIL single_beat got v=%b d=%h id=%0d exp v=1 d=a5 id=103", out_valid_rr, out_data_rr, out_id_rr); end
    tick();
    n_tests++; if (out_valid_rr !== 1'b0) begin n_fail++; $display("FAIL single_after got %b exp 0", out_valid_rr); end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int c = 0; c < NUM_CH; c++) in_data[c*DATA_W +: DATA_W] = 8'(c);
    in_valid = '1;
    tick(); tick();
    in_valid = '0;
    out_ready = 1'b1;
    for (int k = 0; k < 2 * NUM_CH; k++) begin
      n_tests++;
      if (out_valid_rr !== 1'b1 || out_id_rr !== 8'(ID_BASE + k % NUM_CH) || out_data_rr !== 8'(k % NUM_CH)) begin
        n_fail++; $display("FAIL rr_seq[%0d] got v=%b id=%0d d=%0d exp v=1 id=%0d d=%0d", k, out_valid_rr, out_id_rr, out_data_rr, ID_BASE + k % NUM_CH, k % NUM_CH);
      end
      tick();
    end
    n_tests++; if (out_valid_rr !== 1'b0) begin n_fail++; $display("FAIL rr_end got %b exp 0", out_valid_rr); end
  endtask

  task automatic test_fixed_priority();
    logic [7:0] exp_d [6];
    logic [7:0] exp_i [6];
    do_reset();
    for (int b = 0; b < 3; b++) begin
      exp_d[b] = 8'(8'h20 + b); exp_i[b] = 8'd102;
      exp_d[b+3] = 8'(8'h70 + b); exp_i[b+3] = 8'd107;
    end
    in_valid[2] = 1'b1; in_valid[7] = 1'b1;
    for (int b = 0; b < 3; b++) begin
      in_data[2*DATA_W +: DATA_W] = 8'(8'h20 + b);
      in_data[7*DATA_W +: DATA_W] = 8'(8'h70 + b);
      tick();
    end
    in_valid = '0;
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      n_tests++;
      if (out_valid_fp !== 1'b1 || out_id_fp !== exp_i[k] || out_data_fp !== exp_d[k]) begin
        n_fail++; $display("FAIL fp_seq[%0d] got v=%b id=%0d d=%h exp v=1 id=%0d d=%h", k, out_valid_fp, out_id_fp, out_data_fp, exp_i[k], exp_d[k]);
      end
      tick();
    end
    n_tests++; if (out_valid_fp !== 1'b0) begin n_fail++; $display("FAIL fp_end got %b exp 0", out_valid_fp); end
  endtask

  task automatic test_backpressure();
    int   sent;
    logic rdy;
    do_reset();
    sent = 0;
    in_valid[0] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      in_data[7:0] = 8'(8'h40 + sent);
      rdy = in_ready_rr[0];
      tick();
      if (rdy) sent++;
      if (k >= 1) begin
        n_tests++; if (out_valid_rr !== 1'b1 || out_data_rr !== 8'h40 || out_id_rr !== 8'd100) begin n_fail++; $display("FAIL bp_hold[%0d] got v=%b d=%h id=%0d exp v=1 d=40 id=100", k, out_valid_rr, out_data_rr, out_id_rr); end
      end
    end
    in_valid = '0;
    n_tests++; if (sent !== 1 + DEPTH) begin n_fail++; $display("FAIL bp_accepted got %0d exp %0d", sent, 1 + DEPTH); end
    n_tests++; if (fifo_level_rr[LVL_W-1:0] !== LVL_W'(DEPTH) || in_ready_rr[0] !== 1'b0) begin n_fail++; $display("FAIL bp_full got lvl=%0d rdy=%b exp lvl=4 rdy=0", fifo_level_rr[LVL_W-1:0], in_ready_rr[0]); end
    out_ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      n_tests++; if (out_valid_rr !== 1'b1 || out_data_rr !== 8'(8'h40 + j)) begin n_fail++; $display("FAIL bp_drain[%0d] got v=%b d=%h exp v=1 d=%h", j, out_valid_rr, out_data_rr, 8'h40 + j); end
      tick();
    end
    n_tests++; if (out_valid_rr !== 1'b0) begin n_fail++; $display("FAIL bp_drain_end got %b exp 0", out_valid_rr); end
  endtask

  task automatic test_push_pop();
    do_reset();
    in_valid[5] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_data[5*DATA_W +: DATA_W] = 8'(k);
      tick();
    end
    n_tests++; if (fifo_level_rr[5*LVL_W +: LVL_W] !== 3'd2 || out_data_rr !== 8'd0) begin n_fail++; $display("FAIL pp_pre got lvl=%0d d=%0d exp lvl=2 d=0", fifo_level_rr[5*LVL_W +: LVL_W], out_data_rr); end
    out_ready = 1'b1;
    for (int k = 3; k < 8; k++) begin
      in_data[5*DATA_W +: DATA_W] = 8'(k);
      tick();
      n_tests++; if (fifo_level_rr[5*LVL_W +: LVL_W] !== 3'd2 || out_data_rr !== 8'(k - 2) || out_id_rr !== 8'd105) begin n_fail++; $display("FAIL pp_steady[%0d] got lvl=%0d d=%0d id=%0d exp lvl=2 d=%0d id=105", k, fifo_level_rr[5*LVL_W +: LVL_W], out_data_rr, out_id_rr, k - 2); end
    end
    in_valid = '0;
    for (int k = 6; k < 8; k++) begin
      tick();
      n_tests++; if (out_valid_rr !== 1'b1 || out_data_rr !== 8'(k)) begin n_fail++; $display("FAIL pp_tail[%0d] got v=%b d=%0d exp v=1 d=%0d", k, out_valid_rr, out_data_rr, k); end
    end
  endtask

  task automatic test_random();
    logic [NUM_CH*LVL_W-1:0] exp_lvl;
    logic [NUM_CH-1:0]       exp_rdy;
    logic                    a_v;
    logic [DATA_W-1:0]       a_d;
    logic [ID_W-1:0]         a_i;
    logic [NUM_CH*LVL_W-1:0] a_l;
    logic [NUM_CH-1:0]       a_r;
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        in_valid[c] = ($urandom_range(0, 2) == 0);
        in_data[c*DATA_W +: DATA_W] = 8'($urandom);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
      for (int m = 0; m < 2; m++) begin
        a_v = (m == 0) ? out_valid_rr  : out_valid_fp;
        a_d = (m == 0) ? out_data_rr   : out_data_fp;
        a_i = (m == 0) ? out_id_rr     : out_id_fp;
        a_l = (m == 0) ? fifo_level_rr : fifo_level_fp;
        a_r = (m == 0) ? in_ready_rr   : in_ready_fp;
        for (int c = 0; c < NUM_CH; c++) begin
          exp_lvl[c*LVL_W +: LVL_W] = LVL_W'(m_cnt[m][c]);
          exp_rdy[c] = (m_cnt[m][c] < DEPTH);
        end
        n_tests++; if (a_v !== m_ov[m] || a_d !== m_od[m] || a_i !== m_oid[m]) begin n_fail++; $display("FAIL rand_out m%0d cyc%0d got v=%b d=%h id=%0d exp v=%b d=%h id=%0d", m, cyc, a_v, a_d, a_i, m_ov[m], m_od[m], m_oid[m]); end
        n_tests++; if (a_l !== exp_lvl || a_r !== exp_rdy) begin n_fail++; $display("FAIL rand_fifo m%0d cyc%0d got lvl=%h rdy=%h exp lvl=%h rdy=%h", m, cyc, a_l, a_r, exp_lvl, exp_rdy); end
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    model_reset();
    test_reset();
    test_single_beat();
    test_round_robin();
    test_fixed_priority();
    test_backpressure();
    test_push_pop();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/simple_bus_rr_mux.md
Name: simple_bus_rr_mux

Overview:
- Parametrised N-channel merge stage for simple_bus-style producers instantiated from a generate loop.
- Each channel has its own valid/ready input and a private FIFO of configurable depth.
- An arbiter, either round-robin or fixed-priority, drains the FIFOs into one registered valid/ready output.
- Every output beat carries a channel tag equal to ID_BASE plus the channel index, so downstream logic can identify the source without extra wiring.

Parameters:
- NUM_CH, 10, number of input channels (≥1).
- DATA_W, 8, payload width per channel.
- DEPTH, 4, per-channel FIFO depth in entries. Must be a power of two, ≥2.
- ID_BASE, 100, tag offset. out_id = ID_BASE + channel index.
- ID_W, 8, width of out_id. Must satisfy ID_BASE+NUM_CH-1 < 2**ID_W.
- PRIO_MODE, 0. 0 = round-robin, 1 = fixed priority with lowest index winning.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  NUM_CH  per-channel valid; bit i belongs to channel i.
- in_ready  output  NUM_CH  per-channel ready; equals "FIFO i not full".
- in_data  input  NUM_CH*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W].
- out_valid  output  1  output register holds a beat.
- out_ready  input  1  downstream accept.
- out_data  output  DATA_W  payload of the held beat.
- out_id  output  ID_W  ID_BASE + source channel index.
- fifo_level  output  NUM_CH*($clog2(DEPTH)+1)  per-channel occupancy, 0..DEPTH.

Behaviour:
- Reset (async assert, deassert on any edge):
  - All FIFOs empty, all fifo_level = 0, all in_ready = 1.
  - out_valid = 0, out_data = 0, out_id = 0.
  - Round-robin pointer = NUM_CH-1, so channel 0 is considered first.
- Write rule: FIFO i pushes in_data slice i on a rising edge when in_valid[i] && in_ready[i].
  - in_ready[i] depends only on FIFO i state, with no combinational path from in_valid or out_ready.
  - When FIFO i is full, in_ready[i] = 0 even if the arbiter pops it in the same cycle. No same-cycle pass-through at full.
- Load condition: load = !out_valid || out_ready.
- Arbitration happens every cycle in which load is true. Candidates are channels whose FIFO is non-empty at the start of the cycle.
  - PRIO_MODE=0: grant the first candidate searching from pointer+1 modulo NUM_CH upward. On a grant, pointer := granted index.
  - PRIO_MODE=1: grant the lowest-index candidate. The pointer is unused.
- On a grant with load true:
  - Pop the granted FIFO.
  - out_data := popped entry, out_id := ID_BASE + index (truncated to ID_W), out_valid := 1.
- If load is true and there is no candidate, out_valid := 0. out_data and out_id keep their last values.
- If out_valid && !out_ready, out_valid/out_data/out_id hold stable. No pops, and the pointer does not move.
- Latency: a beat written at edge t is presented at out_valid no earlier than after edge t+1. The FIFO is not bypassed.
- Throughput: with out_ready held at 1 and traffic present, one beat per cycle.
- Simultaneous push and pop on the same FIFO: level unchanged, data order preserved. At level 0 the pop cannot occur because the FIFO is not a candidate.
- FIFO pointers wrap at DEPTH. Level arithmetic is ($clog2(DEPTH)+1) bits wide so that the full state is representable.
- NUM_CH=1: the arbiter degenerates to "grant 0 when non-empty". out_id is constantly ID_BASE once loaded.
- Reset asserted mid-transfer: all queued data is discarded and outputs go to their reset values immediately, without waiting for an edge.
- Per-channel FIFO and handshake logic is generated in a labelled loop over channel index. Instances are addressable hierarchically by channel index.

Test Plan:
- Reset values: assert rst mid-cycle with data queued -> out_valid=0, out_id=0, in_ready all 1, fifo_level all 0 before the next edge.
- Single beat: channel 3 pushes 0xA5 at edge t with out_ready=1 -> after edge t+1: out_valid=1, out_data=0xA5, out_id=103. After edge t+2: out_valid=0.
- Round-robin fairness:
  - Stimulus: PRIO_MODE=0, all 10 channels preloaded with 2 beats each (data = channel index), out_ready=1.
  - Required: out_id sequence 100,101,…,109,100,…,109. 20 consecutive valid cycles.
- Fixed priority:
  - Stimulus: PRIO_MODE=1, channels 2 and 7 loaded with 3 beats each, out_ready=1.
  - Required: ids 102,102,102,107,107,107.
- Backpressure and full:
  - Stimulus: out_ready=0, channel 0 pushes continuously.
  - Required: after 1 beat moves to the output register and DEPTH=4 more are written, fifo_level[0]=4 and in_ready[0]=0. out_data/out_id stay stable.
  - Then raise out_ready: exactly 5 beats drain in order.
- Simultaneous push/pop:
  - Stimulus: channel 5 at level 2, push and pop in the same cycle.
  - Required: level stays 2 and FIFO order is preserved across a pointer wrap (push 8 beats total through a DEPTH=4 FIFO, values 0..7 out in order).
